// File: rtl/handshake_arbiter.sv
// N-channel valid/ready arbiter merging producer streams onto one registered,
// channel-tagged consumer stream; round-robin or fixed priority, optional packet lock.
module handshake_arbiter #(
   parameter int unsigned VALUE_BITS  = 8,
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned ROUND_ROBIN = 1,
   parameter int unsigned LOCK_PACKET = 0,
   localparam int unsigned CB = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [CHANNELS*VALUE_BITS-1:0] i_value,
   input  logic [CHANNELS-1:0]            i_last,
   input  logic [CHANNELS-1:0]            i_valid,
   output logic [CHANNELS-1:0]            o_ready,
   output logic [VALUE_BITS-1:0]          o_value,
   output logic                           o_last,
   output logic [CB-1:0]                  o_channel,
   output logic                           o_valid,
   input  logic                           i_ready
);

   localparam int unsigned CW = CB + 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   lock_state_t            state;
   lock_state_t            state_next;
   logic [CB-1:0]          lock_ch;
   logic [CB-1:0]          lock_ch_next;
   logic [CB-1:0]          ptr;
   logic [CB-1:0]          ptr_next;
   logic [CB-1:0]          ptr_inc;
   logic                   found;
   logic [CB-1:0]          gidx;
   logic [CW-1:0]          cand;
   logic                   load_en;
   logic                   accept;
   logic [VALUE_BITS-1:0]  sel_value;
   logic                   sel_last;

   // Grant search: locked channel only, else rotating or lowest-index priority
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      cand  = '0;
      if (state == LOCKED) begin
         found = i_valid[lock_ch];
         gidx  = lock_ch;
      end else if (ROUND_ROBIN != 0) begin
         for (int j = 0; j < CHANNELS; j++) begin
            cand = {1'b0, ptr} + CW'(j);
            if (cand >= CW'(CHANNELS)) begin
               cand = cand - CW'(CHANNELS);
            end
            if (!found && i_valid[cand[CB-1:0]]) begin
               found = 1'b1;
               gidx  = cand[CB-1:0];
            end
         end
      end else begin
         for (int j = 0; j < CHANNELS; j++) begin
            if (!found && i_valid[j]) begin
               found = 1'b1;
               gidx  = CB'(j);
            end
         end
      end
   end

   assign load_en = !o_valid | i_ready;
   assign accept  = found & load_en & !reset;
   assign o_ready = accept ? (CHANNELS'(1) << gidx) : '0;
   assign ptr_inc = (gidx == CB'(CHANNELS - 1)) ? '0 : gidx + CB'(1);

   // Payload mux for the granted channel
   always_comb begin
      sel_value = '0;
      sel_last  = 1'b0;
      for (int j = 0; j < CHANNELS; j++) begin
         if (gidx == CB'(j)) begin
            sel_value = i_value[j*VALUE_BITS +: VALUE_BITS];
            sel_last  = i_last[j];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         lock_ch <= '0;
         ptr     <= '0;
      end else begin
         state   <= state_next;
         lock_ch <= lock_ch_next;
         ptr     <= ptr_next;
      end
   end

   // Lock FSM and pointer advance; in lock mode the pointer moves only on packet end
   always_comb begin
      state_next   = state;
      lock_ch_next = lock_ch;
      ptr_next     = ptr;
      if (accept) begin
         if (LOCK_PACKET != 0) begin
            case (state)
               IDLE: begin
                  if (!sel_last) begin
                     state_next   = LOCKED;
                     lock_ch_next = gidx;
                  end
               end
               LOCKED: begin
                  if (sel_last) begin
                     state_next = IDLE;
                  end
               end
            endcase
            if (sel_last && (ROUND_ROBIN != 0)) begin
               ptr_next = ptr_inc;
            end
         end else if (ROUND_ROBIN != 0) begin
            ptr_next = ptr_inc;
         end
      end
   end

   // One-entry output register: load wins over drain, holds data when drained
   always_ff @(posedge clock) begin
      if (reset) begin
         o_valid   <= 1'b0;
         o_value   <= '0;
         o_last    <= 1'b0;
         o_channel <= '0;
      end else if (accept) begin
         o_valid   <= 1'b1;
         o_value   <= sel_value;
         o_last    <= sel_last;
         o_channel <= gidx;
      end else if (i_ready) begin
         o_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_handshake_arbiter.sv
// Bench for handshake_arbiter: three instances (round-robin, fixed priority,
// round-robin with packet lock) share stimulus and are checked against a rule-level model.
module tb_handshake_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] i_value;
   logic [3:0]  i_last;
   logic [3:0]  i_valid;
   logic        i_ready;

   logic [3:0]  o_ready   [3];
   logic [7:0]  o_value   [3];
   logic        o_last    [3];
   logic [1:0]  o_channel [3];
   logic        o_valid   [3];

   int checks = 0;
   int passed = 0;

   // Reference model state per instance
   int          m_ptr  [3];
   bit          m_lock [3];
   int          m_lch  [3];
   bit          m_ov   [3];
   logic [7:0]  m_val  [3];
   bit          m_last [3];
   int          m_ch   [3];

   always #5 clock = ~clock;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      handshake_arbiter #(
         .VALUE_BITS (8),
         .CHANNELS   (4),
         .ROUND_ROBIN((k == 1) ? 0 : 1),
         .LOCK_PACKET((k == 2) ? 1 : 0)
      ) dut (
         .clock    (clock),
         .reset    (reset),
         .i_value  (i_value),
         .i_last   (i_last),
         .i_valid  (i_valid),
         .o_ready  (o_ready[k]),
         .o_value  (o_value[k]),
         .o_last   (o_last[k]),
         .o_channel(o_channel[k]),
         .o_valid  (o_valid[k]),
         .i_ready  (i_ready)
      );
   end

   function automatic bit is_rr(int k);
      return k != 1;
   endfunction

   function automatic bit is_lk(int k);
      return k == 2;
   endfunction

   // Which channel the rules grant this cycle, -1 for none
   function automatic int grant_of(int k);
      int c;
      if (reset) return -1;
      if (m_ov[k] && !i_ready) return -1;
      if (is_lk(k) && m_lock[k]) return i_valid[2'(m_lch[k])] ? m_lch[k] : -1;
      for (int j = 0; j < 4; j++) begin
         c = is_rr(k) ? (m_ptr[k] + j) % 4 : j;
         if (i_valid[2'(c)]) return c;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready(int k);
      int g;
      g = grant_of(k);
      return (g < 0) ? 4'b0000 : 4'(1 << g);
   endfunction

   task automatic model_step();
      int g;
      for (int k = 0; k < 3; k++) begin
         if (reset) begin
            m_ov[k] = 0; m_val[k] = 8'h00; m_last[k] = 0; m_ch[k] = 0;
            m_ptr[k] = 0; m_lock[k] = 0; m_lch[k] = 0;
         end else begin
            g = grant_of(k);
            if (g >= 0) begin
               m_ov[k]   = 1;
               m_val[k]  = i_value[g*8 +: 8];
               m_last[k] = i_last[2'(g)];
               m_ch[k]   = g;
               if (is_lk(k)) begin
                  if (!m_lock[k] && !i_last[2'(g)]) begin
                     m_lock[k] = 1;
                     m_lch[k]  = g;
                  end else if (i_last[2'(g)]) begin
                     m_lock[k] = 0;
                     if (is_rr(k)) m_ptr[k] = (g + 1) % 4;
                  end
               end else if (is_rr(k)) begin
                  m_ptr[k] = (g + 1) % 4;
               end
            end else if (m_ov[k] && i_ready) begin
               m_ov[k] = 0;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic apply_reset();
      reset = 1'b1; i_valid = 4'b0000; i_last = 4'b0000; i_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; i_valid = 4'b1111; i_last = 4'b0000; i_ready = 1'b1;
      i_value = 32'h1312_1110;
      repeat (3) begin
         tick();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_valid[k] !== 1'b0) $display("FAIL reset_valid inst%0d got %b want 0", k, o_valid[k]);
            else passed++;
            checks++;
            if (o_ready[k] !== 4'b0000) $display("FAIL reset_ready inst%0d got %b want 0000", k, o_ready[k]);
            else passed++;
            checks++;
            if (o_value[k] !== 8'h00) $display("FAIL reset_value inst%0d got %h want 00", k, o_value[k]);
            else passed++;
         end
      end
      reset = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (o_ready[k] !== 4'b0001) $display("FAIL first_grant inst%0d got %b want 0001", k, o_ready[k]);
         else passed++;
      end
      tick();
      checks++;
      if (o_channel[0] !== 2'd0 || o_value[0] !== 8'h10)
         $display("FAIL first_beat got ch%0d %h want ch0 10", o_channel[0], o_value[0]);
      else passed++;
   endtask

   task automatic test_rr_fairness();
      apply_reset();
      i_value = 32'h1312_1110; i_valid = 4'b1111; i_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (o_ready[0] !== 4'(1 << (i % 4))) $display("FAIL rr_ready beat%0d got %b want %b", i, o_ready[0], 4'(1 << (i % 4)));
         else passed++;
         tick();
         checks++;
         if (o_valid[0] !== 1'b1 || o_channel[0] !== 2'(i % 4) || o_value[0] !== 8'(8'h10 + i % 4))
            $display("FAIL rr_beat beat%0d got v%b ch%0d %h want v1 ch%0d %h", i, o_valid[0],
                     o_channel[0], o_value[0], i % 4, 8'h10 + i % 4);
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      i_value = 32'h0000_0042; i_valid = 4'b0001; i_ready = 1'b1;
      tick();
      checks++;
      if (o_valid[0] !== 1'b1 || o_value[0] !== 8'h42) $display("FAIL bp_load got v%b %h want v1 42", o_valid[0], o_value[0]);
      else passed++;
      i_ready = 1'b0; i_value = 32'h0000_0055;
      repeat (5) begin
         #1;
         checks++;
         if (o_ready[0] !== 4'b0000) $display("FAIL bp_ready got %b want 0000", o_ready[0]);
         else passed++;
         tick();
         checks++;
         if (o_valid[0] !== 1'b1 || o_value[0] !== 8'h42 || o_channel[0] !== 2'd0)
            $display("FAIL bp_hold got v%b ch%0d %h want v1 ch0 42", o_valid[0], o_channel[0], o_value[0]);
         else passed++;
      end
      i_ready = 1'b1;
      #1;
      checks++;
      if (o_ready[0] !== 4'b0001) $display("FAIL bp_release_ready got %b want 0001", o_ready[0]);
      else passed++;
      tick();
      checks++;
      if (o_valid[0] !== 1'b1 || o_value[0] !== 8'h55) $display("FAIL bp_reload got v%b %h want v1 55", o_valid[0], o_value[0]);
      else passed++;
   endtask

   task automatic test_fixed_priority();
      apply_reset();
      i_value = 32'h3322_1100; i_valid = 4'b0110; i_ready = 1'b1;
      repeat (4) begin
         #1;
         checks++;
         if (o_ready[1] !== 4'b0010) $display("FAIL fp_ready got %b want 0010", o_ready[1]);
         else passed++;
         tick();
         checks++;
         if (o_channel[1] !== 2'd1 || o_value[1] !== 8'h11) $display("FAIL fp_beat got ch%0d %h want ch1 11", o_channel[1], o_value[1]);
         else passed++;
      end
      i_valid = 4'b0100;
      #1;
      checks++;
      if (o_ready[1] !== 4'b0100) $display("FAIL fp_drop_ready got %b want 0100", o_ready[1]);
      else passed++;
      tick();
      checks++;
      if (o_channel[1] !== 2'd2 || o_value[1] !== 8'h22) $display("FAIL fp_drop_beat got ch%0d %h want ch2 22", o_channel[1], o_value[1]);
      else passed++;
   endtask

   task automatic test_packet_lock();
      apply_reset();
      i_value = {8'h33, 8'hA0, 8'h11, 8'h01}; i_ready = 1'b1;
      i_valid = 4'b0010; i_last = 4'b0010;
      tick();
      i_valid = 4'b0101; i_last = 4'b0000;
      #1;
      checks++;
      if (o_ready[2] !== 4'b0100) $display("FAIL lk_start_ready got %b want 0100", o_ready[2]);
      else passed++;
      tick();
      checks++;
      if (o_channel[2] !== 2'd2 || o_value[2] !== 8'hA0) $display("FAIL lk_beat0 got ch%0d %h want ch2 a0", o_channel[2], o_value[2]);
      else passed++;
      i_value[23:16] = 8'hA1;
      #1;
      checks++;
      if (o_ready[2] !== 4'b0100) $display("FAIL lk_beat1_ready got %b want 0100", o_ready[2]);
      else passed++;
      tick();
      checks++;
      if (o_channel[2] !== 2'd2 || o_value[2] !== 8'hA1) $display("FAIL lk_beat1 got ch%0d %h want ch2 a1", o_channel[2], o_value[2]);
      else passed++;
      i_valid = 4'b0001;
      repeat (2) begin
         #1;
         checks++;
         if (o_ready[2] !== 4'b0000) $display("FAIL lk_gap_ready got %b want 0000", o_ready[2]);
         else passed++;
         tick();
         checks++;
         if (o_valid[2] !== 1'b0) $display("FAIL lk_gap_bubble got v%b want v0", o_valid[2]);
         else passed++;
      end
      i_valid = 4'b0101; i_last = 4'b0100; i_value[23:16] = 8'hA2;
      #1;
      checks++;
      if (o_ready[2] !== 4'b0100) $display("FAIL lk_last_ready got %b want 0100", o_ready[2]);
      else passed++;
      tick();
      checks++;
      if (o_valid[2] !== 1'b1 || o_value[2] !== 8'hA2 || o_last[2] !== 1'b1)
         $display("FAIL lk_last_beat got v%b %h last%b want v1 a2 last1", o_valid[2], o_value[2], o_last[2]);
      else passed++;
      i_last = 4'b0000; i_valid = 4'b1101;
      #1;
      checks++;
      if (o_ready[2] !== 4'b1000) $display("FAIL lk_ptr3 got %b want 1000", o_ready[2]);
      else passed++;
      i_valid = 4'b0101;
      #1;
      checks++;
      if (o_ready[2] !== 4'b0001) $display("FAIL lk_ch0_ready got %b want 0001", o_ready[2]);
      else passed++;
      tick();
      checks++;
      if (o_channel[2] !== 2'd0 || o_value[2] !== 8'h01) $display("FAIL lk_ch0_beat got ch%0d %h want ch0 01", o_channel[2], o_value[2]);
      else passed++;
   endtask

   task automatic test_mid_packet_reset();
      apply_reset();
      i_value = {8'h33, 8'h22, 8'h11, 8'h00}; i_valid = 4'b0010; i_last = 4'b0000; i_ready = 1'b0;
      tick();
      checks++;
      if (o_valid[2] !== 1'b1 || o_channel[2] !== 2'd1) $display("FAIL mr_locked got v%b ch%0d want v1 ch1", o_valid[2], o_channel[2]);
      else passed++;
      reset = 1'b1;
      tick();
      checks++;
      if (o_valid[2] !== 1'b0) $display("FAIL mr_discard got v%b want v0", o_valid[2]);
      else passed++;
      reset = 1'b0; i_valid = 4'b1000; i_ready = 1'b1;
      #1;
      checks++;
      if (o_ready[2] !== 4'b1000) $display("FAIL mr_idle_ready got %b want 1000", o_ready[2]);
      else passed++;
      tick();
      checks++;
      if (o_channel[2] !== 2'd3 || o_value[2] !== 8'h33) $display("FAIL mr_ch3 got ch%0d %h want ch3 33", o_channel[2], o_value[2]);
      else passed++;
   endtask

   task automatic test_random();
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         reset   = ($urandom_range(0, 49) == 0);
         i_valid = 4'($urandom);
         i_last  = 4'($urandom);
         i_value = $urandom;
         i_ready = ($urandom_range(0, 3) != 0);
         #1;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_ready[k] !== exp_ready(k)) $display("FAIL rnd_ready inst%0d cyc%0d got %b want %b", k, n, o_ready[k], exp_ready(k));
            else passed++;
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_valid[k] !== m_ov[k] || o_value[k] !== m_val[k] || o_channel[k] !== 2'(m_ch[k]) || o_last[k] !== m_last[k])
               $display("FAIL rnd_out inst%0d cyc%0d got v%b %h ch%0d l%b want v%b %h ch%0d l%b", k, n,
                        o_valid[k], o_value[k], o_channel[k], o_last[k], m_ov[k], m_val[k], m_ch[k], m_last[k]);
            else passed++;
         end
      end
   endtask

   initial begin
      reset = 1'b1; i_valid = 4'b0000; i_last = 4'b0000; i_ready = 1'b1; i_value = 32'h0;
      @(negedge clock);
      test_reset();
      test_rr_fairness();
      test_backpressure();
      test_fixed_priority();
      test_packet_lock();
      test_mid_packet_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
